instruction_fetch_unit: RTL and testbench

- Program-counter sequencer and fetch stage that sits directly upstream of the instruction memory.
- Drives the word address into the combinational-read instruction memory and registers the returned 32-bit instruction.
- Presents the instruction and its PC to the decode stage over a valid/ready handshake.
- Handles start, branch/jump redirect with flush, back-pressure stall, and halt-opcode detection.

---
 rtl/instruction_fetch_unit_if.sv | 60 ++++++
 rtl/instruction_fetch_unit.sv | 117 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: the control inputs, the instruction-memory port and the decode handshake.
// The fetch unit uses the slave modport and the surrounding pipeline uses the master modport.
interface instruction_fetch_unit_if #(
   parameter int unsigned INST_LENGTH = 32,
   parameter int unsigned ADDR_WIDTH  = 16
);

   // Control from the surrounding pipeline
   logic                   start;
   logic [ADDR_WIDTH-1:0]  start_pc;
   logic                   redirect_valid;
   logic [ADDR_WIDTH-1:0]  redirect_pc;

   // Instruction memory (combinational read)
   logic [ADDR_WIDTH-1:0]  imem_addr;
   logic [INST_LENGTH-1:0] imem_rdata;

   // Decode handshake
   logic                   inst_valid;
   logic                   inst_ready;
   logic [INST_LENGTH-1:0] inst_out;
   logic [ADDR_WIDTH-1:0]  inst_pc;

   // Status
   logic                   busy;
   logic                   halted;

   // Pipeline / memory side
   modport master (
      output start,
      output start_pc,
      output redirect_valid,
      output redirect_pc,
      input  imem_addr,
      output imem_rdata,
      input  inst_valid,
      output inst_ready,
      input  inst_out,
      input  inst_pc,
      input  busy,
      input  halted
   );

   // Fetch unit side
   modport slave (
      input  start,
      input  start_pc,
      input  redirect_valid,
      input  redirect_pc,
      output imem_addr,
      input  imem_rdata,
      output inst_valid,
      input  inst_ready,
      output inst_out,
      output inst_pc,
      output busy,
      output halted
   );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: sequences the PC, reads the combinational instruction memory and
// holds one registered instruction for decode behind a valid/ready handshake.
// Handles start, redirect with flush, back-pressure stall and halt-opcode detection.
module instruction_fetch_unit #(
   parameter int unsigned INST_LENGTH = 32,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned OPCODE_MSB  = 31,
   parameter int unsigned OPCODE_LSB  = 26,
   parameter logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE = 6'b111111
) (
   input logic                       clk,
   input logic                       rst_n,
   instruction_fetch_unit_if.slave   fu_io
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StHalted = 2'd2
   } state_e;

   state_e                 state_q;
   logic [ADDR_WIDTH-1:0]  pc_q;
   logic                   inst_valid_q;
   logic [INST_LENGTH-1:0] inst_out_q;
   logic [ADDR_WIDTH-1:0]  inst_pc_q;

   logic                   slot_free;
   logic                   halt_hit;
   logic [ADDR_WIDTH-1:0]  pc_inc;

   // Capture-slot availability, halt decode of the word being read, and the wrapping PC increment
   always_comb begin
      slot_free = !inst_valid_q || fu_io.inst_ready;
      halt_hit  = (fu_io.imem_rdata[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
      pc_inc    = pc_q + 1'b1;
   end

   // Fetch sequencer: state, PC and the registered instruction slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         pc_q         <= '0;
         inst_valid_q <= 1'b0;
         inst_out_q   <= '0;
         inst_pc_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (fu_io.start) begin
                  pc_q    <= fu_io.start_pc;
                  state_q <= StRun;
               end
            end

            StRun: begin
               if (fu_io.redirect_valid) begin
                  // Flush wins even over a stalled slot; the word at the old PC is dropped
                  pc_q         <= fu_io.redirect_pc;
                  inst_valid_q <= 1'b0;
               end else if (slot_free) begin
                  inst_out_q   <= fu_io.imem_rdata;
                  inst_pc_q    <= pc_q;
                  inst_valid_q <= 1'b1;
                  if (halt_hit) begin
                     // PC parks on the halt instruction
                     state_q <= StHalted;
                  end else begin
                     pc_q <= pc_inc;
                  end
               end
            end

            StHalted: begin
               if (fu_io.start) begin
                  pc_q         <= fu_io.start_pc;
                  inst_valid_q <= 1'b0;
                  state_q      <= StRun;
               end else if (fu_io.inst_ready) begin
                  // Halt instruction is handed over exactly once
                  inst_valid_q <= 1'b0;
               end
            end

            default: begin
               state_q      <= StIdle;
               inst_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Outputs come straight from flops; status decodes from the state register
   always_comb begin
      fu_io.imem_addr  = pc_q;
      fu_io.inst_valid = inst_valid_q;
      fu_io.inst_out   = inst_out_q;
      fu_io.inst_pc    = inst_pc_q;
      fu_io.busy       = (state_q == StRun);
      fu_io.halted     = (state_q == StHalted);
   end

`ifndef SYNTHESIS
   // A presented instruction must not change under back-pressure
   stall_stable_a: assert property (
      @(posedge clk) disable iff (!rst_n)
      (inst_valid_q && !fu_io.inst_ready) |=> ($stable(inst_out_q) && $stable(inst_pc_q))
   );

   // Busy and halted are mutually exclusive
   status_excl_a: assert property (
      @(posedge clk) disable iff (!rst_n)
      !(fu_io.busy && fu_io.halted)
   );
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a transaction-level model checked every cycle,
// plus hand-computed literal expectations for start, stall, redirect, halt, wrap and reset.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

   logic clk;
   logic rst_n;

   instruction_fetch_unit_if #(.INST_LENGTH(32), .ADDR_WIDTH(16)) bus ();

   instruction_fetch_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fu_io (bus)
   );

   int total;
   int bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: low 256 words from a table, everything else synthesised from the address
   logic [31:0] mem [0:255];
   assign bus.imem_rdata = (bus.imem_addr < 16'd256) ? mem[bus.imem_addr[7:0]]
                                                     : {6'h01, 10'h000, bus.imem_addr};

   function automatic logic [31:0] word_at(input int a);
      logic [15:0] a16;
      a16 = a[15:0];
      if (a16 < 16'd256) return mem[a16[7:0]];
      return {6'h01, 10'h000, a16};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mode, fetch pointer and the one-deep delivery slot
   int          m_mode;   // 0 idle, 1 fetching, 2 stopped on halt
   int          m_pc;
   bit          m_v;
   logic [31:0] m_out;
   int          m_ipc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode <= 0;
         m_pc   <= 0;
         m_v    <= 1'b0;
         m_out  <= '0;
         m_ipc  <= 0;
      end else if (m_mode == 0) begin
         if (bus.start) begin
            m_pc   <= int'(bus.start_pc);
            m_mode <= 1;
         end
      end else if (m_mode == 1) begin
         if (bus.redirect_valid) begin
            m_pc <= int'(bus.redirect_pc);
            m_v  <= 1'b0;
         end else if (!m_v || bus.inst_ready) begin
            m_v   <= 1'b1;
            m_out <= word_at(m_pc);
            m_ipc <= m_pc;
            if (word_at(m_pc) >> 26 == 32'h3f) m_mode <= 2;
            else m_pc <= (m_pc + 1) % 65536;
         end
      end else begin
         if (bus.start) begin
            m_pc   <= int'(bus.start_pc);
            m_v    <= 1'b0;
            m_mode <= 1;
         end else if (bus.inst_ready) begin
            m_v <= 1'b0;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_addr",   64'(bus.imem_addr),  64'(m_pc));
         chk("m_valid",  64'(bus.inst_valid), 64'(m_v));
         chk("m_busy",   64'(bus.busy),       64'(m_mode == 1));
         chk("m_halted", 64'(bus.halted),     64'(m_mode == 2));
         if (m_v) begin
            chk("m_out", 64'(bus.inst_out), 64'(m_out));
            chk("m_pc",  64'(bus.inst_pc),  64'(m_ipc));
         end
      end
   end

   // Log of accepted beats (PC of each handshake)
   int beat_log [$];
   always @(posedge clk) begin
      if (rst_n && bus.inst_valid && bus.inst_ready) beat_log.push_back(int'(bus.inst_pc));
   end

   function automatic int beats_of(input int pc);
      int n;
      n = 0;
      foreach (beat_log[i]) if (beat_log[i] == pc) n++;
      return n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0400_0000 | 32'(i);
      mem[3] = 32'hFC00_0000;
      mem[4] = 32'hA000_0001;
      mem[5] = 32'hA000_0002;
      mem[6] = 32'hA000_0003;
      mem[7] = 32'hA000_0004;
      bus.start          = 1'b0;
      bus.start_pc       = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.inst_ready     = 1'b0;
      rst_n              = 1'b0;

      #2;
      chk("rst_addr",   64'(bus.imem_addr),  64'h0);
      chk("rst_valid",  64'(bus.inst_valid), 64'h0);
      chk("rst_busy",   64'(bus.busy),       64'h0);
      chk("rst_halted", 64'(bus.halted),     64'h0);
      chk("rst_out",    64'(bus.inst_out),   64'h0);
      chk("rst_ipc",    64'(bus.inst_pc),    64'h0);
      #10 rst_n = 1'b1;

      // Start at 4, streaming with ready high
      tick();
      bus.start = 1'b1; bus.start_pc = 16'h0004; bus.inst_ready = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("start_addr",  64'(bus.imem_addr),  64'h4);
      chk("start_valid", 64'(bus.inst_valid), 64'h0);
      chk("start_busy",  64'(bus.busy),       64'h1);
      tick();
      chk("b0_valid", 64'(bus.inst_valid), 64'h1);
      chk("b0_pc",    64'(bus.inst_pc),    64'h4);
      chk("b0_out",   64'(bus.inst_out),   64'hA000_0001);
      tick();
      chk("b1_pc",   64'(bus.inst_pc),   64'h5);
      chk("b1_out",  64'(bus.inst_out),  64'hA000_0002);
      chk("b1_addr", 64'(bus.imem_addr), 64'h6);

      // Back-pressure on the pc-5 beat
      bus.inst_ready = 1'b0;
      repeat (3) begin
         tick();
         chk("stall_valid", 64'(bus.inst_valid), 64'h1);
         chk("stall_pc",    64'(bus.inst_pc),    64'h5);
         chk("stall_out",   64'(bus.inst_out),   64'hA000_0002);
         chk("stall_addr",  64'(bus.imem_addr),  64'h6);
      end
      bus.inst_ready = 1'b1;
      tick();
      chk("b2_pc",  64'(bus.inst_pc),  64'h6);
      chk("b2_out", 64'(bus.inst_out), 64'hA000_0003);
      tick();
      chk("b3_pc",  64'(bus.inst_pc),  64'h7);
      chk("b3_out", 64'(bus.inst_out), 64'hA000_0004);
      tick();
      chk("b4_pc",  64'(bus.inst_pc),  64'h8);
      tick();
      chk("b5_pc",  64'(bus.inst_pc),  64'h9);

      // Redirect while stalled on pc 9
      bus.inst_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0020;
      tick();
      bus.redirect_valid = 1'b0;
      chk("redir_valid", 64'(bus.inst_valid), 64'h0);
      chk("redir_addr",  64'(bus.imem_addr),  64'h20);
      tick();
      chk("redir_bvalid", 64'(bus.inst_valid), 64'h1);
      chk("redir_bpc",    64'(bus.inst_pc),    64'h20);
      chk("redir_bout",   64'(bus.inst_out),   64'h0400_0020);

      // Redirect to 1 and run into the halt word at 3
      bus.inst_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0001;
      tick();
      bus.redirect_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("halt_pc",     64'(bus.inst_pc),    64'h3);
      chk("halt_out",    64'(bus.inst_out),   64'hFC00_0000);
      chk("halt_halted", 64'(bus.halted),     64'h1);
      chk("halt_busy",   64'(bus.busy),       64'h0);
      chk("halt_addr",   64'(bus.imem_addr),  64'h3);
      tick();
      chk("halt_drain", 64'(bus.inst_valid), 64'h0);
      repeat (3) tick();
      chk("halt_idle_valid", 64'(bus.inst_valid), 64'h0);
      chk("halt_idle_addr",  64'(bus.imem_addr),  64'h3);
      chk("once_pc3", 64'(beats_of(3)), 64'd1);
      chk("once_pc5", 64'(beats_of(5)), 64'd1);
      chk("once_pc6", 64'(beats_of(6)), 64'd1);
      chk("none_pc9", 64'(beats_of(9)), 64'd0);

      // Restart from 0 after halt
      bus.start = 1'b1; bus.start_pc = 16'h0000;
      tick();
      bus.start = 1'b0;
      chk("restart_busy", 64'(bus.busy),      64'h1);
      chk("restart_addr", 64'(bus.imem_addr), 64'h0);
      tick();
      chk("restart_pc",  64'(bus.inst_pc),  64'h0);
      chk("restart_out", 64'(bus.inst_out), 64'h0400_0000);
      repeat (3) tick();
      chk("rehalt", 64'(bus.halted), 64'h1);
      tick();

      // PC wrap from 0xFFFF
      bus.start = 1'b1; bus.start_pc = 16'hFFFF;
      tick();
      bus.start = 1'b0;
      chk("wrap_addr", 64'(bus.imem_addr), 64'hFFFF);
      tick();
      chk("wrap_pc0",  64'(bus.inst_pc),   64'hFFFF);
      chk("wrap_out0", 64'(bus.inst_out),  64'h0400_FFFF);
      tick();
      chk("wrap_pc1",  64'(bus.inst_pc),   64'h0);
      chk("wrap_out1", 64'(bus.inst_out),  64'h0400_0000);
      chk("wrap_addr1", 64'(bus.imem_addr), 64'h1);

      // Asynchronous reset between edges
      #3 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(bus.inst_valid), 64'h0);
      chk("arst_busy",  64'(bus.busy),       64'h0);
      chk("arst_addr",  64'(bus.imem_addr),  64'h0);
      chk("arst_ipc",   64'(bus.inst_pc),    64'h0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (3) tick();
      chk("post_rst_busy",  64'(bus.busy),       64'h0);
      chk("post_rst_valid", 64'(bus.inst_valid), 64'h0);
      bus.start = 1'b1; bus.start_pc = 16'h0004;
      tick();
      bus.start = 1'b0;
      tick();
      chk("resume_pc",  64'(bus.inst_pc),  64'h4);
      chk("resume_out", 64'(bus.inst_out), 64'hA000_0001);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
